// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, row/column key map and scanner FSM states.
// Also used by the calculator core so both sides agree on the code values.
package keypad_pkg;

    localparam logic [3:0] KEY_PLUS     = 4'hA;
    localparam logic [3:0] KEY_MINUS    = 4'hB;
    localparam logic [3:0] KEY_MULTIPLY = 4'hC;
    localparam logic [3:0] KEY_DIVIDE   = 4'hD;
    localparam logic [3:0] KEY_CLEAR    = 4'hE;
    localparam logic [3:0] KEY_DP       = 4'hF;

    localparam int KEY_CODE_W = 25;

    // Indexed by {row, col}.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, KEY_PLUS,
        4'h4, 4'h5, 4'h6, KEY_MINUS,
        4'h7, 4'h8, 4'h9, KEY_MULTIPLY,
        KEY_DP, 4'h0, KEY_CLEAR, KEY_DIVIDE
    };

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col}];
    endfunction

    // Index of the (only) low bit; caller guarantees exactly one zero.
    function automatic logic [1:0] low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones so an
// idle (pulled-up) keypad reads as no key during and after reset.
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debounce, producing
// the key_pressed / keypad_out pair consumed by the calculator core.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            row_in,
    output logic [3:0]            col_out,
    output logic                  key_pressed,
    output logic [KEY_CODE_W-1:0] keypad_out
);

    localparam int DW_W = $clog2(SCAN_DIV);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0] DB_DONE = DB_W'(DEBOUNCE_CYCLES);

    logic [3:0]      w_rs;
    logic            w_one_low;
    logic [1:0]      w_low_row;
    logic [DB_W-1:0] w_db_next;

    state_t          r_state;
    logic [DW_W-1:0] r_dwell;
    logic [DB_W-1:0] r_db;
    logic [1:0]      r_col;
    logic [1:0]      r_row;
    logic [3:0]      r_cand;
    logic            r_key_pressed;
    logic [3:0]      r_code;

    keypad_sync #(.WIDTH(4)) u_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (row_in),
        .o_q   (w_rs)
    );

    // Two or more low rows in one column is treated as no key.
    assign w_one_low = $onehot(~w_rs);
    assign w_low_row = low_row(w_rs);
    assign w_db_next = r_db + DB_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_SCAN;
            r_dwell       <= '0;
            r_db          <= '0;
            r_col         <= 2'd0;
            r_row         <= 2'd0;
            r_cand        <= 4'hF;
            r_key_pressed <= 1'b0;
            r_code        <= 4'h0;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (r_dwell == DW_LAST) begin
                        r_dwell <= '0;
                        if (w_one_low) begin
                            r_row   <= w_low_row;
                            r_cand  <= w_rs;
                            r_db    <= '0;
                            r_state <= ST_DEBOUNCE;
                        end else begin
                            r_col <= r_col + 2'd1;
                        end
                    end else begin
                        r_dwell <= r_dwell + DW_W'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_rs != r_cand) begin
                        r_col   <= r_col + 2'd1;
                        r_dwell <= '0;
                        r_state <= ST_SCAN;
                    end else begin
                        r_db <= w_db_next;
                        if (w_db_next == DB_DONE) begin
                            r_code        <= key_code(r_row, r_col);
                            r_key_pressed <= 1'b1;
                            r_state       <= ST_PRESSED;
                        end
                    end
                end
                ST_PRESSED: begin
                    // Only the accepted row matters; other keys are ignored.
                    if (w_rs[r_row]) begin
                        r_db    <= '0;
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!w_rs[r_row]) begin
                        r_state <= ST_PRESSED;
                    end else begin
                        r_db <= w_db_next;
                        if (w_db_next == DB_DONE) begin
                            r_key_pressed <= 1'b0;
                            r_col         <= r_col + 2'd1;
                            r_dwell       <= '0;
                            r_state       <= ST_SCAN;
                        end
                    end
                end
                default: r_state <= ST_SCAN;
            endcase
        end
    end

    assign col_out     = 4'hF ^ (4'h1 << r_col);
    assign key_pressed = r_key_pressed;
    assign keypad_out  = {{(KEY_CODE_W-4){1'b0}}, r_code};

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: matrix keypad model, cycle reference model
// of the scanning rules, and hand-computed expectations for each scenario.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        key_pressed;
    logic [24:0] keypad_out;

    logic [15:0] held;          // bit r*4+c: key (r,c) physically held
    int          checks = 0;
    int          passes = 0;
    int          rises = 0;
    logic [24:0] rise_code = '0;
    logic        prev_kp = 1'b0;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk         (clk),
        .rst         (rst),
        .row_in      (row_in),
        .col_out     (col_out),
        .key_pressed (key_pressed),
        .keypad_out  (keypad_out)
    );

    // Matrix: a row reads low when a held key in that row sits on a driven column.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (held[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    int code_tab [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 15, 0, 14, 13};
    localparam int M_SCAN = 0, M_CONFIRM = 1, M_HELD = 2, M_LETGO = 3;
    int         m_mode, m_col, m_elapsed, m_stable, m_r, m_c, m_code;
    logic       m_kp;
    logic [3:0] m_s1, m_s2, m_rs, m_pat;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = 4'hF; m_s2 = 4'hF; m_mode = M_SCAN; m_col = 0;
            m_elapsed = 0; m_stable = 0; m_kp = 1'b0; m_code = 0;
            m_r = 0; m_c = 0; m_pat = 4'hF;
        end else begin
            int zeros, idx;
            m_rs = m_s2; m_s2 = m_s1; m_s1 = row_in;
            zeros = 0; idx = 0;
            for (int i = 0; i < 4; i++) if (!m_rs[i]) begin zeros++; idx = i; end
            case (m_mode)
                M_SCAN: begin
                    m_elapsed++;
                    if (m_elapsed == SD) begin
                        m_elapsed = 0;
                        if (zeros == 1) begin
                            m_r = idx; m_c = m_col; m_pat = m_rs; m_stable = 0; m_mode = M_CONFIRM;
                        end else m_col = (m_col + 1) % 4;
                    end
                end
                M_CONFIRM: begin
                    if (m_rs != m_pat) begin
                        m_mode = M_SCAN; m_col = (m_col + 1) % 4; m_elapsed = 0;
                    end else begin
                        m_stable++;
                        if (m_stable == DB) begin
                            m_kp = 1'b1; m_code = code_tab[m_r*4 + m_c]; m_mode = M_HELD;
                        end
                    end
                end
                M_HELD: if (m_rs[m_r]) begin m_stable = 0; m_mode = M_LETGO; end
                default: begin
                    if (!m_rs[m_r]) m_mode = M_HELD;
                    else begin
                        m_stable++;
                        if (m_stable == DB) begin
                            m_kp = 1'b0; m_col = (m_col + 1) % 4; m_elapsed = 0; m_mode = M_SCAN;
                        end
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison against the model, plus rising-edge bookkeeping.
    always @(posedge clk) begin
        #1;
        check("col_out", {28'b0, col_out}, {28'b0, 4'hF ^ (4'h1 << m_col)});
        check("key_pressed", {31'b0, key_pressed}, {31'b0, m_kp});
        check("keypad_out", {7'b0, keypad_out}, m_code);
        if (key_pressed && !prev_kp) begin
            rises++;
            rise_code = keypad_out;
        end
        prev_kp = key_pressed;
    end

    task automatic wait_kp(input logic lvl, input int lim, input string nm);
        int n;
        n = 0;
        while (key_pressed !== lvl && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(nm, {31'b0, key_pressed}, {31'b0, lvl});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_col_out", {28'b0, col_out}, 32'hE);
        check("rst_key_pressed", {31'b0, key_pressed}, 32'h0);
        check("rst_keypad_out", {7'b0, keypad_out}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rises = 0;
    endtask

    logic [3:0] rot [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    initial begin
        int n;
        held = '0;
        #2 rst = 1'b1;

        // Reset values and column rotation, 4 cycles per column.
        do_reset();
        for (int j = 0; j < 20; j++) begin
            check("col_rotation", {28'b0, col_out}, {28'b0, rot[(j/4) % 4]});
            @(negedge clk);
        end

        // Clean press of key (1,1) -> code 5.
        do_reset();
        held[1*4+1] = 1'b1;
        repeat (60) @(negedge clk);
        check("clean_rises", rises, 1);
        check("clean_code", {7'b0, rise_code}, 32'h5);
        held = '0;
        repeat (10) @(negedge clk);
        check("clean_still_high", {31'b0, key_pressed}, 32'h1);
        @(negedge clk);
        check("clean_fall", {31'b0, key_pressed}, 32'h0);
        check("clean_code_kept", {7'b0, keypad_out}, 32'h5);
        check("clean_rises_after", rises, 1);

        // Bouncy press of key (0,3) while column 3 is driven -> code A.
        do_reset();
        n = 0;
        while (col_out !== 4'b0111 && n < 40) begin @(negedge clk); n++; end
        check("reach_col3", {28'b0, col_out}, 32'h7);
        for (int t = 0; t < 3; t++) begin
            held[0*4+3] = 1'b1; @(negedge clk);
            held[0*4+3] = 1'b0; @(negedge clk);
        end
        held[0*4+3] = 1'b1;
        repeat (60) @(negedge clk);
        check("bouncy_rises", rises, 1);
        check("bouncy_code", {7'b0, rise_code}, 32'hA);
        held = '0;
        wait_kp(1'b0, 40, "bouncy_release");
        check("bouncy_code_kept", {7'b0, keypad_out}, 32'hA);

        // Two keys in column 0 -> never accepted.
        do_reset();
        held[0*4+0] = 1'b1;
        held[1*4+0] = 1'b1;
        repeat (60) @(negedge clk);
        check("twokey_rises", rises, 0);
        check("twokey_kp", {31'b0, key_pressed}, 32'h0);
        held = '0;

        // Release bounce on key (3,0): short release is absorbed.
        do_reset();
        held[3*4+0] = 1'b1;
        wait_kp(1'b1, 60, "relbounce_press");
        repeat (5) @(negedge clk);
        held = '0;
        repeat (3) @(negedge clk);
        held[3*4+0] = 1'b1;
        repeat (30) @(negedge clk);
        check("relbounce_kp", {31'b0, key_pressed}, 32'h1);
        check("relbounce_rises", rises, 1);
        check("relbounce_code", {7'b0, rise_code}, 32'hF);
        held = '0;
        wait_kp(1'b0, 40, "relbounce_release");

        // Reset mid-press on key (3,2), key held through reset -> new pulse, code E.
        do_reset();
        held[3*4+2] = 1'b1;
        wait_kp(1'b1, 60, "midrst_press");
        repeat (3) @(negedge clk);
        do_reset();
        wait_kp(1'b1, 60, "midrst_repress");
        check("midrst_rises", rises, 1);
        check("midrst_code", {7'b0, rise_code}, 32'hE);
        held = '0;
        wait_kp(1'b0, 40, "midrst_release");

        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
